// File: rtl/imem_arb.sv
// imem_arb: fetch/load arbiter for a single-port instruction memory; define IMEM_ARB_ERR_EN to return errors for bad fetch addresses
module imem_arb #(
    parameter int ADDR_W     = 6,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              f_req,
    input  logic [31:0]       f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [31:0]       f_rdata,
    output logic              f_err,
    output logic              stall_f,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [31:0]       l_addr,
    input  logic [31:0]       l_wdata,
    input  logic              l_lock,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [31:0]       l_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
    localparam logic RUN  = 1'b0;
    localparam logic HALT = 1'b1;

    logic          state;
    logic [SW-1:0] starve;
    logic          v;
    logic          own;
    logic          wr;
    logic          fe;
    logic          f_bad;
    logic          unused;

`ifdef IMEM_ARB_ERR_EN
    assign f_bad = (f_addr[1:0] != 2'b00) || (f_addr[31:ADDR_W+2] != '0);
`else
    assign f_bad = 1'b0;
`endif

    assign unused   = ^{l_addr[1:0], l_addr[31:ADDR_W+2], f_addr[1:0], f_addr[31:ADDR_W+2]};
    assign l_gnt    = l_req && (state == HALT || !f_req || starve == SMAX);
    assign f_gnt    = f_req && state == RUN && !l_gnt;
    assign stall_f  = f_req && !f_gnt;
    assign m_en     = l_gnt || (f_gnt && !f_bad);
    assign m_we     = l_gnt && l_we;
    assign m_addr   = l_gnt ? l_addr[ADDR_W+1:2] : f_addr[ADDR_W+1:2];
    assign m_wdata  = (l_gnt && l_we) ? l_wdata : '0;
    assign f_rvalid = v && !own;
    assign f_err    = f_rvalid && fe;
    assign f_rdata  = (f_rvalid && !fe) ? m_rdata : '0;
    assign l_rvalid = v && own;
    assign l_rdata  = (l_rvalid && !wr) ? m_rdata : '0;

    // halt fetch for as long as l_lock is sampled high
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= RUN;
        else state <= l_lock ? HALT : RUN;
    end

    // count fetch grants taken while a load waits, saturating at the limit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) starve <= '0;
        else if (!l_req || l_gnt) starve <= '0;
        else if (f_gnt && starve != SMAX) starve <= starve + 1'b1;
    end

    // remember who owns next cycle's response and what kind it is
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v   <= 1'b0;
            own <= 1'b0;
            wr  <= 1'b0;
            fe  <= 1'b0;
        end else begin
            v   <= f_gnt || l_gnt;
            own <= l_gnt;
            wr  <= l_gnt && l_we;
            fe  <= f_gnt && f_bad;
        end
    end
endmodule

// File: tb/tb_imem_arb.sv
// tb_imem_arb: directed and randomized checks of imem_arb against a behavioural model
module tb_imem_arb;
    localparam int AW = 6;
    localparam int SM = 4;
`ifdef IMEM_ARB_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          f_req = 1'b0;
    logic [31:0]   f_addr = '0;
    logic          f_gnt, f_rvalid, f_err, stall_f;
    logic [31:0]   f_rdata;
    logic          l_req = 1'b0, l_we = 1'b0, l_lock = 1'b0;
    logic [31:0]   l_addr = '0, l_wdata = '0;
    logic          l_gnt, l_rvalid;
    logic [31:0]   l_rdata;
    logic          m_en, m_we;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_wdata;
    logic [31:0]   m_rdata = '0;
    logic [31:0]   mem [64];
    logic [31:0]   ref_mem [64];
    int            n_tests = 0;
    int            n_fail = 0;

    imem_arb #(.ADDR_W(AW), .STARVE_MAX(SM)) dut (
        .clk(clk), .reset_n(reset_n),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
        .f_rdata(f_rdata), .f_err(f_err), .stall_f(stall_f),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_lock(l_lock), .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) mem[m_addr] <= m_wdata;
            m_rdata <= mem[m_addr];
        end
    end

    task automatic drive(input logic fr, input logic [31:0] fa, input logic lr, input logic lwe,
                         input logic [31:0] la, input logic [31:0] lwd, input logic lk);
        f_req = fr; f_addr = fa; l_req = lr; l_we = lwe; l_addr = la; l_wdata = lwd; l_lock = lk;
    endtask

    task automatic test_reset();
        logic [11:0] outs;
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        outs = {f_gnt, f_rvalid, f_err, stall_f, l_gnt, l_rvalid, m_en, m_we, |f_rdata, |l_rdata, |m_wdata, |m_addr};
        n_tests++;
        if (outs !== 12'h0) begin n_fail++; $display("FAIL reset_outputs got=%b want=0", outs); end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fetch_read();
        mem[7] = 32'h00990663;
        @(negedge clk);
        drive(1, 32'h1C, 0, 0, 0, 0, 0);
        #1;
        n_tests++;
        if ({f_gnt, stall_f, m_en, m_we} !== 4'b1010) begin n_fail++; $display("FAIL fetch_grant got=%b want=1010", {f_gnt, stall_f, m_en, m_we}); end
        n_tests++;
        if (m_addr !== 6'd7) begin n_fail++; $display("FAIL fetch_maddr got=%0d want=7", m_addr); end
        @(negedge clk);
        #1;
        n_tests++;
        if ({f_rvalid, f_err, l_rvalid} !== 3'b100) begin n_fail++; $display("FAIL fetch_rvalid got=%b want=100", {f_rvalid, f_err, l_rvalid}); end
        n_tests++;
        if (f_rdata !== 32'h00990663) begin n_fail++; $display("FAIL fetch_rdata got=%h want=00990663", f_rdata); end
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_starvation();
        logic prev_l = 1'b0;
        logic exp_l;
        mem[3] = 32'hA5A50003;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            n_tests++;
            if (l_rvalid !== prev_l) begin n_fail++; $display("FAIL starve_lrvalid cyc=%0d got=%b want=%b", i, l_rvalid, prev_l); end
            if (prev_l) begin
                n_tests++;
                if (l_rdata !== 32'hA5A50003) begin n_fail++; $display("FAIL starve_lrdata cyc=%0d got=%h want=a5a50003", i, l_rdata); end
            end
            drive(1, 32'h1C, 1, 0, 32'hC, 0, 0);
            #1;
            exp_l = (i % 5) == 4;
            n_tests++;
            if ({l_gnt, f_gnt, stall_f} !== {exp_l, !exp_l, exp_l}) begin
                n_fail++;
                $display("FAIL starve_pattern cyc=%0d got=%b want=%b", i, {l_gnt, f_gnt, stall_f}, {exp_l, !exp_l, exp_l});
            end
            prev_l = exp_l;
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_lock();
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 1);
        #1;
        n_tests++;
        if (f_gnt !== 1'b1) begin n_fail++; $display("FAIL lock_same_cycle got=%b want=1", f_gnt); end
        @(negedge clk);
        drive(1, 0, 1, 1, 0, 32'h00100493, 1);
        #1;
        n_tests++;
        if ({f_gnt, stall_f, l_gnt, m_en, m_we} !== 5'b01111) begin n_fail++; $display("FAIL lock_halt got=%b want=01111", {f_gnt, stall_f, l_gnt, m_en, m_we}); end
        n_tests++;
        if (m_addr !== 6'd0 || m_wdata !== 32'h00100493) begin n_fail++; $display("FAIL lock_write got=%0d/%h want=0/00100493", m_addr, m_wdata); end
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 1);
        #1;
        n_tests++;
        if ({l_rvalid, f_rvalid, f_gnt} !== 3'b100 || l_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL lock_write_ack got=%b rdata=%h want=100 rdata=0", {l_rvalid, f_rvalid, f_gnt}, l_rdata);
        end
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0);
        #1;
        n_tests++;
        if ({f_gnt, stall_f} !== 2'b01) begin n_fail++; $display("FAIL lock_release_halted got=%b want=01", {f_gnt, stall_f}); end
        @(negedge clk);
        #1;
        n_tests++;
        if ({f_gnt, stall_f} !== 2'b10) begin n_fail++; $display("FAIL lock_resume got=%b want=10", {f_gnt, stall_f}); end
        @(negedge clk);
        #1;
        n_tests++;
        if (f_rvalid !== 1'b1 || f_rdata !== 32'h00100493) begin n_fail++; $display("FAIL lock_readback got=%b/%h want=1/00100493", f_rvalid, f_rdata); end
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_err_addr();
        mem[0] = 32'h00000013;
        @(negedge clk);
        drive(1, 32'h102, 0, 0, 0, 0, 0);
        #1;
        n_tests++;
        if ({f_gnt, m_en} !== {1'b1, !ERR}) begin n_fail++; $display("FAIL err_grant got=%b want=%b", {f_gnt, m_en}, {1'b1, !ERR}); end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        n_tests++;
        if ({f_rvalid, f_err} !== {1'b1, ERR}) begin n_fail++; $display("FAIL err_flag got=%b want=%b", {f_rvalid, f_err}, {1'b1, ERR}); end
        n_tests++;
        if (f_rdata !== (ERR ? 32'h0 : 32'h00000013)) begin n_fail++; $display("FAIL err_rdata got=%h want=%h", f_rdata, ERR ? 32'h0 : 32'h13); end
    endtask

    task automatic test_reset_inflight();
        logic [11:0] outs;
        @(negedge clk);
        drive(1, 32'h1C, 0, 0, 0, 0, 0);
        #1;
        n_tests++;
        if (f_gnt !== 1'b1) begin n_fail++; $display("FAIL rst_pre_grant got=%b want=1", f_gnt); end
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        outs = {f_gnt, f_rvalid, f_err, stall_f, l_gnt, l_rvalid, m_en, m_we, |f_rdata, |l_rdata, |m_wdata, |m_addr};
        n_tests++;
        if (outs !== 12'h0) begin n_fail++; $display("FAIL rst_inflight_outputs got=%b want=0", outs); end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_tests++;
            if (f_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_no_rvalid cyc=%0d got=%b want=0", i, f_rvalid); end
        end
        drive(1, 32'h1C, 0, 0, 0, 0, 0);
        #1;
        n_tests++;
        if (f_gnt !== 1'b1) begin n_fail++; $display("FAIL rst_resume_grant got=%b want=1", f_gnt); end
        @(negedge clk);
        #1;
        n_tests++;
        if (f_rvalid !== 1'b1 || f_rdata !== 32'h00990663) begin n_fail++; $display("FAIL rst_resume_data got=%b/%h want=1/00990663", f_rvalid, f_rdata); end
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        bit halt = 0, pf = 0, pe = 0, pl = 0;
        int waited = 0;
        logic [31:0] pd = '0, pld = '0;
        logic fr, lr, lwe, lk = 0, eg_f, eg_l, err;
        logic [31:0] fa, la, lwd;
        logic [AW-1:0] idx;
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            n_tests++;
            if ({f_rvalid, f_err, l_rvalid} !== {pf, pf && pe, pl}) begin
                n_fail++;
                $display("FAIL rand_valid cyc=%0d got=%b want=%b", c, {f_rvalid, f_err, l_rvalid}, {pf, pf && pe, pl});
            end
            n_tests++;
            if (f_rdata !== ((pf && !pe) ? pd : 32'h0) || l_rdata !== (pl ? pld : 32'h0)) begin
                n_fail++;
                $display("FAIL rand_rdata cyc=%0d got=%h/%h want=%h/%h", c, f_rdata, l_rdata, (pf && !pe) ? pd : 32'h0, pl ? pld : 32'h0);
            end
            fr = ($urandom % 4) != 0;
            lr = ($urandom % 3) == 0;
            lwe = $urandom % 2;
            if ($urandom % 16 == 0) lk = !lk;
            fa = ($urandom % 4 == 0) ? $urandom : 4 * ($urandom % 64);
            la = ($urandom % 4 == 0) ? $urandom : 4 * ($urandom % 64);
            lwd = $urandom;
            drive(fr, fa, lr, lwe, la, lwd, lk);
            #1;
            eg_l = lr && (halt || !fr || waited == SM);
            eg_f = fr && !halt && !eg_l;
            err = ERR && eg_f && ((fa % 4) != 0 || fa >= 4 * 64);
            idx = AW'(((eg_l ? la : fa) / 4) % 64);
            n_tests++;
            if ({f_gnt, l_gnt, stall_f} !== {eg_f, eg_l, fr && !eg_f}) begin
                n_fail++;
                $display("FAIL rand_grant cyc=%0d got=%b want=%b", c, {f_gnt, l_gnt, stall_f}, {eg_f, eg_l, fr && !eg_f});
            end
            n_tests++;
            if ({m_en, m_we} !== {eg_l || (eg_f && !err), eg_l && lwe}) begin
                n_fail++;
                $display("FAIL rand_mem_ctl cyc=%0d got=%b want=%b", c, {m_en, m_we}, {eg_l || (eg_f && !err), eg_l && lwe});
            end
            if (eg_l || (eg_f && !err)) begin
                n_tests++;
                if (m_addr !== idx) begin n_fail++; $display("FAIL rand_maddr cyc=%0d got=%0d want=%0d", c, m_addr, idx); end
            end
            pf = eg_f;
            pe = err;
            pd = ref_mem[idx];
            pl = eg_l;
            pld = lwe ? 32'h0 : ref_mem[idx];
            if (eg_l && lwe) ref_mem[idx] = lwd;
            if (!lr || eg_l) waited = 0;
            else if (eg_f && waited < SM) waited++;
            halt = lk;
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        test_reset();
        test_fetch_read();
        test_starvation();
        test_lock();
        test_err_addr();
        test_reset_inflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_arb.md
IMEM_ARB -- requirements
Module: imem_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, meaning log2 of memory depth in 32-bit words (64 words).
REQ-002 SHALL have parameter STARVE_MAX, default 4, meaning maximum consecutive fetch grants while a load request waits.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port f_req, input, 1, fetch-port read request.
REQ-006 SHALL have port f_addr, input, 32, fetch byte address.
REQ-007 SHALL have port f_gnt, output, 1, fetch request accepted this cycle.
REQ-008 SHALL have port f_rvalid, output, 1, fetch read data valid.
REQ-009 SHALL have port f_rdata, output, 32, fetch read data.
REQ-010 SHALL have port f_err, output, 1, fetch address error, qualified by f_rvalid.
REQ-011 SHALL have port stall_f, output, 1, pipeline fetch stall, equal to f_req and not f_gnt.
REQ-012 SHALL have port l_req, input, 1, load/debug port request.
REQ-013 SHALL have port l_we, input, 1, load-port write enable.
REQ-014 SHALL have ports l_addr (input, 32) and l_wdata (input, 32), the load-port byte address and write data.
REQ-015 SHALL have port l_lock, input, 1, load-port request to halt fetch for program load.
REQ-016 SHALL have ports l_gnt (output, 1), l_rvalid (output, 1) and l_rdata (output, 32), the load-port handshake and response.
REQ-017 SHALL have memory ports m_en (output, 1), m_we (output, 1), m_addr (output, ADDR_W), m_wdata (output, 32) and m_rdata (input, 32), driving a single-port memory with 1-cycle synchronous read.

Function
REQ-018 SHALL grant at most one of f_gnt/l_gnt per cycle; grants are combinational from requests and registered state.
REQ-019 SHALL, in state RUN, grant fetch by default; load is granted when f_req is low, or when the starvation counter equals STARVE_MAX.
REQ-020 SHALL increment the starvation counter on each fetch grant while l_req is high, clear it on a load grant or when l_req is low, and saturate it at STARVE_MAX.
REQ-021 SHALL move RUN->HALT on the edge where l_lock is sampled high; the fetch arbitration in that same cycle is unaffected.
REQ-022 SHALL keep f_gnt low in HALT, grant every l_req immediately, and return HALT->RUN on the edge where l_lock is sampled low.
REQ-023 SHALL drive m_en high on any grant, with m_we = l_we for load grants, 0 for fetch grants, and m_addr = granted address bits [ADDR_W+1:2].
REQ-024 SHALL assert the owner's rvalid exactly one cycle after its grant, with rdata = m_rdata, using a registered owner bit.
REQ-025 SHALL return l_rdata = 0 for write acknowledges.
REQ-026 SHALL hold f_rdata and l_rdata at 0 whenever the corresponding rvalid is low.
REQ-027 SHALL sustain back-to-back grants at one access per cycle with no bubble.

Reset
REQ-028 SHALL, on reset_n low, immediately force state RUN, starvation counter 0, owner/valid registers 0, and all outputs 0 except combinational terms, which shall evaluate from the reset state.
REQ-029 SHALL discard any in-flight response at reset; no rvalid pulse shall be produced after reset_n rises for a request granted before reset.

Configuration
REQ-030 SHALL, with IMEM_ARB_ERR_EN defined, treat a fetch with f_addr[1:0]!=0 or any f_addr bit above ADDR_W+1 set as an error: grant it, keep m_en low, and one cycle later pulse f_rvalid with f_err=1 and f_rdata=0.
REQ-031 SHALL, without IMEM_ARB_ERR_EN, drop the upper and low address bits (index wraps modulo depth) and tie f_err to 0.

Verification
REQ-032 SHALL cover: f_req held high, f_addr=0x1C, memory word 7 = 0x00990663 -> f_gnt=1 same cycle, f_rvalid=1 with f_rdata=0x00990663 next cycle.
REQ-033 SHALL cover: f_req and l_req both held high continuously -> pattern of 4 fetch grants followed by 1 load grant, repeating.
REQ-034 SHALL cover: l_lock pulsed high, then writes of 0x00100493 to address 0x0 -> f_gnt low and stall_f high from the next cycle, the write is acknowledged, and fetch resumes one cycle after l_lock falls.
REQ-035 SHALL cover, with IMEM_ARB_ERR_EN defined: f_addr=0x102 -> f_err=1, f_rdata=0, m_en=0; without the macro, the same address reads word 0.
REQ-036 SHALL cover: reset_n asserted low in the cycle after a fetch grant -> no f_rvalid, all outputs 0, and normal grants resume after release.
